alu_mp_seq: RTL and testbench

Multi-precision sequencer for the shared `alu` datapath. It performs an add or subtract on WORDS×N-bit operands by stepping one N-bit `alu` instance through the operands one slice per cycle, least significant slice first, chaining the carry between slices. It sits between the core's operand registers and the `alu`. It is the only block that drives the `alu` op, operand and carry inputs during a wide operation.

---
 rtl/alu_mp_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_mp_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// Multi-precision add/subtract sequencer stepping one N-bit alu slice per cycle, LSB slice first.
// Optional abort input enabled by defining ALU_MP_SEQ_ABORT_EN.

package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASS
    } alu_op_e;
endpackage

module alu
    import alu_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  alu_op_e        op,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           cin,
    output logic [n-1:0]   out,
    output logic           cout,
    output logic           overflow,
    output logic           zero
);
    logic [n:0] sum;

    always_comb begin
        sum      = '0;
        out      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                sum      = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
                out      = sum[n-1:0];
                cout     = sum[n];
                overflow = (a[n-1] == b[n-1]) && (out[n-1] != a[n-1]);
            end
            ALU_SUB: begin
                // cin is a borrow-in: a + ~b + (1 - cin)
                sum      = {1'b0, a} + {1'b0, ~b} + {{n{1'b0}}, ~cin};
                out      = sum[n-1:0];
                cout     = sum[n];
                overflow = (a[n-1] != b[n-1]) && (out[n-1] != a[n-1]);
            end
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_PASS: out = a;
            default:  out = '0;
        endcase
        zero = (out == '0);
    end
endmodule

module alu_mp_seq
    import alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ALU_MP_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 overflow,
    output logic                 sign,
    output logic                 zero
);
    localparam int unsigned W  = N * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e state, state_nxt;

    logic [W-1:0]  a_r, b_r, acc, acc_nxt;
    logic          sub_r, cin_r, carry, zacc;
    logic [KW-1:0] k;

    logic [N-1:0]  slice_a, slice_b, slice_out;
    logic          slice_cin, slice_cout, slice_ovf, slice_zero;
    logic          accept, last, kill;

`ifdef ALU_MP_SEQ_ABORT_EN
    assign kill = abort && (state == RUN);
`else
    assign kill = 1'b0;
`endif

    assign accept = start && (state != RUN);
    assign last   = (k == KLAST);

    // Subtraction is folded into an add: invert B and convert borrow-in to carry-in.
    assign slice_a   = a_r[k*N +: N];
    assign slice_b   = b_r[k*N +: N] ^ {N{sub_r}};
    assign slice_cin = (k == '0) ? (cin_r ^ sub_r) : carry;

    alu #(.n(N)) u_alu (
        .op       (ALU_ADD),
        .a        (slice_a),
        .b        (slice_b),
        .cin      (slice_cin),
        .out      (slice_out),
        .cout     (slice_cout),
        .overflow (slice_ovf),
        .zero     (slice_zero)
    );

    always_comb begin
        acc_nxt              = acc;
        acc_nxt[k*N +: N]    = slice_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (kill)      state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            cin_r    <= 1'b0;
            k        <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            zacc     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            sign     <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            cin_r <= cin;
            k     <= '0;
            zacc  <= 1'b1;
        end else if (kill) begin
            k <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= slice_cout;
            zacc  <= zacc & slice_zero;
            if (last) begin
                k        <= '0;
                result   <= acc_nxt;
                cout     <= slice_cout;
                overflow <= slice_ovf;
                sign     <= acc_nxt[W-1];
                zero     <= zacc & slice_zero;
            end else begin
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_mp_seq.sv
// Scoreboard bench for alu_mp_seq (N=8, WORDS=4); abort scenarios built when ALU_MP_SEQ_ABORT_EN is defined.

module tb_alu_mp_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, sub, cin;
    logic [31:0] a, b;
    logic        ready, busy, done, cout, overflow, sign, zero;
    logic [31:0] result;
`ifdef ALU_MP_SEQ_ABORT_EN
    logic        abort;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic        c, v, s, z;
    } exp_t;

    typedef struct packed {
        logic [31:0] a, b;
        logic        sub, cin;
    } op_t;

    exp_t        sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] prev;

    always #5 clk = ~clk;

    alu_mp_seq #(.N(8), .WORDS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ALU_MP_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .sign     (sign),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: A+B+cin, or A + ~B + (1-cin) for subtract, in 33 bits.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic s, input logic c);
        exp_t        m;
        logic [32:0] t;
        logic [31:0] bb;
        bb  = s ? ~bv : bv;
        t   = {1'b0, av} + {1'b0, bb} + (s ? 33'(1 - int'(c)) : 33'(c));
        m.r = t[31:0];
        m.c = t[32];
        m.v = (av[31] == bb[31]) && (m.r[31] != av[31]);
        m.s = m.r[31];
        m.z = (m.r == 32'd0);
        return m;
    endfunction

    task automatic launch(input logic [31:0] av, input logic [31:0] bv,
                          input logic s, input logic c);
        a     = av;
        b     = bv;
        sub   = s;
        cin   = c;
        start = 1'b1;
        sb.push_back(model(av, bv, s, c));
        @(posedge clk);
    endtask

    task automatic wait_done(input string tag, input bit hold, input logic [31:0] prv);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({tag, ".latency"}, 32'(i), 32'd5);
                chk({tag, ".busy_done"}, 32'(busy), 32'd0);
                chk({tag, ".ready_done"}, 32'(ready), 32'd1);
                if (sb.size() == 0) begin
                    chk({tag, ".sb_empty"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({tag, ".result"}, result, e.r);
                    chk({tag, ".cout"}, 32'(cout), 32'(e.c));
                    chk({tag, ".overflow"}, 32'(overflow), 32'(e.v));
                    chk({tag, ".sign"}, 32'(sign), 32'(e.s));
                    chk({tag, ".zero"}, 32'(zero), 32'(e.z));
                end
                start = 1'b0;
            end else begin
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                chk({tag, ".ready"}, 32'(ready), 32'd0);
                chk({tag, ".hold"}, result, prv);
                if (!hold) start = 1'b0;
                if (i == 2) begin
                    a   = $urandom;
                    b   = $urandom;
                    sub = 1'($urandom_range(0, 1));
                    cin = 1'($urandom_range(0, 1));
                end
            end
        end
        chk({tag, ".timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle.done", 32'(done), 32'd0);
            chk("idle.ready", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t  ops[7];
        exp_t m;
        ops[0] = '{a: 32'h000000FF, b: 32'h00000001, sub: 1'b0, cin: 1'b0};
        ops[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, sub: 1'b0, cin: 1'b0};
        ops[2] = '{a: 32'h7FFFFFFF, b: 32'h00000001, sub: 1'b0, cin: 1'b0};
        ops[3] = '{a: 32'd10,       b: 32'd3,        sub: 1'b1, cin: 1'b0};
        ops[4] = '{a: 32'd3,        b: 32'd10,       sub: 1'b1, cin: 1'b0};
        ops[5] = '{a: 32'd5,        b: 32'd5,        sub: 1'b1, cin: 1'b1};
        ops[6] = '{a: 32'h12345678, b: 32'h0FEDCBA9, sub: 1'b0, cin: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
`ifdef ALU_MP_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst.result", result, 32'd0);
        chk("rst.flags", {28'd0, cout, overflow, sign, zero}, 32'd0);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        idle(1);
        prev = 32'd0;

        // Directed operations; op 1 holds start high throughout RUN.
        for (int i = 0; i < 7; i++) begin
            launch(ops[i].a, ops[i].b, ops[i].sub, ops[i].cin);
            wait_done($sformatf("op%0d", i), (i == 1), prev);
            m    = model(ops[i].a, ops[i].b, ops[i].sub, ops[i].cin);
            prev = m.r;
            idle(2);
        end

        // Back-to-back: second start issued in the DONE cycle.
        launch(32'h00010001, 32'h0000FFFF, 1'b0, 1'b0);
        wait_done("b2b1", 1'b0, prev);
        m    = model(32'h00010001, 32'h0000FFFF, 1'b0, 1'b0);
        prev = m.r;
        launch(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        wait_done("b2b2", 1'b0, prev);
        m    = model(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        prev = m.r;
        idle(2);

        // Reset in the middle of RUN.
        launch(32'hAAAA5555, 32'h00001234, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.result", result, 32'd0);
        chk("midrst.flags", {28'd0, cout, overflow, sign, zero}, 32'd0);
        chk("midrst.ready", 32'(ready), 32'd1);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        chk("midrst.done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        prev  = 32'd0;
        idle(6);

        launch(32'h00C0FFEE, 32'h00000012, 1'b1, 1'b0);
        wait_done("postrst", 1'b0, prev);
        m    = model(32'h00C0FFEE, 32'h00000012, 1'b1, 1'b0);
        prev = m.r;
        idle(2);

`ifdef ALU_MP_SEQ_ABORT_EN
        // Abort on the second RUN cycle.
        launch(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab2.ready", 32'(ready), 32'd1);
        chk("ab2.busy", 32'(busy), 32'd0);
        chk("ab2.done", 32'(done), 32'd0);
        chk("ab2.result", result, prev);
        void'(sb.pop_back());
        idle(6);
        chk("ab2.result_hold", result, prev);

        // Abort on the last slice beats completion.
        launch(32'h33333333, 32'h44444444, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ablast.done", 32'(done), 32'd0);
        chk("ablast.ready", 32'(ready), 32'd1);
        chk("ablast.result", result, prev);
        void'(sb.pop_back());
        idle(6);

        // Abort asserted in DONE alongside a new start: start still accepted.
        launch(32'h00000020, 32'h00000022, 1'b0, 1'b0);
        wait_done("abdone1", 1'b0, prev);
        m     = model(32'h00000020, 32'h00000022, 1'b0, 1'b0);
        prev  = m.r;
        abort = 1'b1;
        launch(32'h00000100, 32'h00000001, 1'b1, 1'b0);
        #1 abort = 1'b0;
        wait_done("abdone2", 1'b0, prev);
        m    = model(32'h00000100, 32'h00000001, 1'b1, 1'b0);
        prev = m.r;
        idle(2);
`endif

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
